// File: rtl/alu_pkg.sv
// Shared constants and types for the iterative integer ALU.
package alu_pkg;

  // RISC-V funct3 operation selects
  localparam logic [2:0] Funct3Add  = 3'b000;
  localparam logic [2:0] Funct3Sll  = 3'b001;
  localparam logic [2:0] Funct3Slt  = 3'b010;
  localparam logic [2:0] Funct3Sltu = 3'b011;
  localparam logic [2:0] Funct3Xor  = 3'b100;
  localparam logic [2:0] Funct3Sr   = 3'b101;
  localparam logic [2:0] Funct3Or   = 3'b110;
  localparam logic [2:0] Funct3And  = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } alu_state_e;

  // Shifts are the only multi-cycle operations
  function automatic logic is_shift_op(input logic [2:0] f3);
    return (f3 == Funct3Sll) || (f3 == Funct3Sr);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the serial shifter: shifts a value by a small amount.
module alu_shift_step #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AMT_W = 6
) (
  input  logic [XLEN-1:0]  i_value,
  input  logic [AMT_W-1:0] i_amount,
  input  logic             i_left,
  input  logic             i_arith,
  output logic [XLEN-1:0]  o_value
);

  logic              w_fill;
  logic [2*XLEN-1:0] w_ext;

  // The MSB of the running value is the original sign for sra, since every earlier step
  // refilled it with that sign.
  assign w_fill = i_arith & i_value[XLEN-1];

  // Right shifts go through a double-width word so the fill bits slide in from the top
  always_comb begin
    w_ext   = {{XLEN{w_fill}}, i_value} >> i_amount;
    o_value = i_left ? (i_value << i_amount) : w_ext[XLEN-1:0];
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative RISC-V integer ALU: single-cycle logic/arith ops, multi-cycle serial shifts.
module iter_alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic            is_imm,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned ShW  = $clog2(XLEN);
  // One extra bit so a step of a full XLEN still fits
  localparam int unsigned AmtW = ShW + 1;

  alu_state_e      r_state, w_state_next;
  logic [XLEN-1:0] r_result, w_result_next;
  logic [ShW-1:0]  r_shamt, w_shamt_next;
  logic            r_left, w_left_next;
  logic            r_arith, w_arith_next;

  logic            w_accept;
  logic [ShW-1:0]  w_shamt_in;
  logic [AmtW-1:0] w_rem;
  logic [AmtW-1:0] w_step_amt;
  logic [AmtW-1:0] w_rem_after;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_alu;

  assign in_ready   = (r_state == StIdle) & ~rst;
  assign out_valid  = (r_state == StDone);
  assign result     = r_result;
  assign w_accept   = in_valid & in_ready;
  assign w_shamt_in = op_b[ShW-1:0];

  // Step size for this cycle: the remaining amount, capped at SHIFT_STEP
  always_comb begin
    w_rem       = AmtW'(r_shamt);
    w_step_amt  = (w_rem < AmtW'(SHIFT_STEP)) ? w_rem : AmtW'(SHIFT_STEP);
    w_rem_after = w_rem - w_step_amt;
  end

  alu_shift_step #(
    .XLEN  (XLEN),
    .AMT_W (AmtW)
  ) u_shift_step (
    .i_value  (r_result),
    .i_amount (w_step_amt),
    .i_left   (r_left),
    .i_arith  (r_arith),
    .o_value  (w_shifted)
  );

  // Single-cycle operations; unused alt encodings fall back to the alt=0 operation
  always_comb begin
    w_alu = '0;
    unique case (funct3)
      Funct3Add:  w_alu = (alt && !is_imm) ? (op_a - op_b) : (op_a + op_b);
      Funct3Slt:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      Funct3Sltu: w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      Funct3Xor:  w_alu = op_a ^ op_b;
      Funct3Or:   w_alu = op_a | op_b;
      Funct3And:  w_alu = op_a & op_b;
      default:    w_alu = '0;
    endcase
  end

  // Next-state logic: capture on accept, iterate the shifter, hold the result until taken
  always_comb begin
    w_state_next  = r_state;
    w_result_next = r_result;
    w_shamt_next  = r_shamt;
    w_left_next   = r_left;
    w_arith_next  = r_arith;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_left_next  = (funct3 == Funct3Sll);
          w_arith_next = (funct3 == Funct3Sr) && alt;
          if (is_shift_op(funct3)) begin
            w_result_next = op_a;
            w_shamt_next  = w_shamt_in;
            w_state_next  = (w_shamt_in == '0) ? StDone : StShift;
          end else begin
            w_result_next = w_alu;
            w_shamt_next  = '0;
            w_state_next  = StDone;
          end
        end
      end
      StShift: begin
        w_result_next = w_shifted;
        w_shamt_next  = w_rem_after[ShW-1:0];
        if (w_rem_after == '0) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State and datapath registers; reset drops any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_result <= '0;
      r_shamt  <= '0;
      r_left   <= 1'b0;
      r_arith  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_result <= w_result_next;
      r_shamt  <= w_shamt_next;
      r_left   <= w_left_next;
      r_arith  <= w_arith_next;
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Randomised self-checking bench for iter_alu, running SHIFT_STEP=1 and SHIFT_STEP=8 side by side.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        alt = 1'b0;
  logic        is_imm = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_ready = 1'b1;

  logic        rdy1, vld1, rdy8, vld8;
  logic [31:0] res1, res8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iter_alu #(.XLEN(32), .SHIFT_STEP(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (rdy1),
    .funct3    (funct3),
    .alt       (alt),
    .is_imm    (is_imm),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (vld1),
    .out_ready (out_ready),
    .result    (res1)
  );

  iter_alu #(.XLEN(32), .SHIFT_STEP(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (rdy8),
    .funct3    (funct3),
    .alt       (alt),
    .is_imm    (is_imm),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (vld8),
    .out_ready (out_ready),
    .result    (res8)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Architectural result of one RV32 ALU instruction
  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic a_alt,
                                          input logic imm, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (f3)
      3'd0: return (a_alt && !imm) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return a_alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Cycles from accept to out_valid
  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] b, input int step);
    int sh;
    sh = int'(b % 32);
    if (f3 == 3'd1 || f3 == 3'd5) return 1 + (sh + step - 1) / step;
    return 1;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic a_alt,
                        input logic imm, input logic [31:0] a, input logic [31:0] b,
                        input bit hold);
    logic [31:0] exp;
    int          lat1, lat8;
    logic [31:0] got1, got8;
    exp  = ref_alu(f3, a_alt, imm, a, b);
    lat1 = 0;
    lat8 = 0;
    got1 = '0;
    got8 = '0;
    @(negedge clk);
    check_eq({tag, ":in_ready1"}, 64'(rdy1), 64'd1);
    check_eq({tag, ":in_ready8"}, 64'(rdy8), 64'd1);
    funct3    = f3;
    alt       = a_alt;
    is_imm    = imm;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    out_ready = !hold;
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    for (int n = 1; n <= 100; n++) begin
      if (lat1 == 0 && vld1) begin
        lat1 = n;
        got1 = res1;
        check_eq({tag, ":busy_ready1"}, 64'(rdy1), 64'd0);
      end
      if (lat8 == 0 && vld8) begin
        lat8 = n;
        got8 = res8;
        check_eq({tag, ":busy_ready8"}, 64'(rdy8), 64'd0);
      end
      if (lat1 != 0 && lat8 != 0) break;
      @(negedge clk);
    end
    check_eq({tag, ":lat1"}, 64'(lat1), 64'(ref_lat(f3, b, 1)));
    check_eq({tag, ":lat8"}, 64'(lat8), 64'(ref_lat(f3, b, 8)));
    check_eq({tag, ":res1"}, 64'(got1), 64'(exp));
    check_eq({tag, ":res8"}, 64'(got8), 64'(exp));
    if (hold) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check_eq({tag, ":hold_vld1"}, 64'(vld1), 64'd1);
        check_eq({tag, ":hold_res1"}, 64'(res1), 64'(exp));
        check_eq({tag, ":hold_rdy1"}, 64'(rdy1), 64'd0);
        check_eq({tag, ":hold_vld8"}, 64'(vld8), 64'd1);
        check_eq({tag, ":hold_res8"}, 64'(res8), 64'(exp));
        check_eq({tag, ":hold_rdy8"}, 64'(rdy8), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_eq({tag, ":release_vld1"}, 64'(vld1), 64'd0);
      check_eq({tag, ":release_rdy1"}, 64'(rdy1), 64'd1);
      check_eq({tag, ":release_vld8"}, 64'(vld8), 64'd0);
      check_eq({tag, ":release_rdy8"}, 64'(rdy8), 64'd1);
    end
  endtask

  initial begin
    logic [2:0]  r_f3;
    logic [31:0] r_b;
    bit          seen_valid;

    // Reset state while rst is held
    @(negedge clk);
    check_eq("rst_vld1", 64'(vld1), 64'd0);
    check_eq("rst_res1", 64'(res1), 64'd0);
    check_eq("rst_rdy1", 64'(rdy1), 64'd0);
    check_eq("rst_rdy8", 64'(rdy8), 64'd0);
    rst = 1'b0;

    // Directed cases
    run_op("add_wrap", 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sub",      3'd0, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 1'b0);
    run_op("addi_alt", 3'd0, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0);
    run_op("sltu",     3'd3, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    run_op("slt",      3'd2, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    run_op("sra31",    3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_001F, 1'b0);
    run_op("srl31",    3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_001F, 1'b0);
    run_op("sll0",     3'd1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0);
    run_op("sll_0x25", 3'd1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0025, 1'b0);
    run_op("sll_alt",  3'd1, 1'b1, 1'b0, 32'h0000_00F1, 32'h0000_0009, 1'b0);
    run_op("or_alt",   3'd6, 1'b1, 1'b0, 32'h00F0_0F00, 32'h0F00_00F0, 1'b0);
    run_op("and_hold", 3'd7, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0FF0_FF00, 1'b1);
    run_op("sra_hold", 3'd5, 1'b1, 1'b1, 32'hF000_1234, 32'h0000_000B, 1'b1);

    // Reset in the middle of a shift discards it
    @(negedge clk);
    funct3   = 3'd5;
    alt      = 1'b1;
    is_imm   = 1'b0;
    op_a     = 32'h8000_0000;
    op_b     = 32'h0000_001F;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midshift_vld1", 64'(vld1), 64'd0);
    rst = 1'b1;
    #1;
    check_eq("rstshift_vld1", 64'(vld1), 64'd0);
    check_eq("rstshift_res1", 64'(res1), 64'd0);
    check_eq("rstshift_vld8", 64'(vld8), 64'd0);
    check_eq("rstshift_res8", 64'(res8), 64'd0);
    check_eq("rstshift_rdy1", 64'(rdy1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (vld1 || vld8) seen_valid = 1'b1;
    end
    check_eq("discarded_op", 64'(seen_valid), 64'd0);
    run_op("xor_after_rst", 3'd4, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0);

    // Random operations
    for (int i = 0; i < 80; i++) begin
      r_f3 = 3'($urandom_range(0, 7));
      r_b  = $urandom;
      if ((i % 4) == 0) r_b = 32'($urandom_range(0, 3)) << 5 | 32'($urandom_range(0, 31));
      run_op($sformatf("rand%0d", i), r_f3, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom, r_b, (i % 10) == 9);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32, 64.
REQ-002 SHALL have parameter SHIFT_STEP, default 1, max bit positions shifted per cycle; power of 2, 1..XLEN.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port funct3  input  3  RISC-V funct3 operation select.
REQ-008 SHALL have port alt  input  1  instruction bit 30 (sub / arithmetic-shift select).
REQ-009 SHALL have port is_imm  input  1  1 = OP-IMM form, 0 = OP (register) form.
REQ-010 SHALL have port op_a  input  XLEN  rs1 value.
REQ-011 SHALL have port op_b  input  XLEN  rs2 value or sign-extended immediate.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port result  output  XLEN  operation result.

Function
REQ-015 SHALL accept a request on a rising clk edge with in_valid=1 and in_ready=1, capturing all operand/control inputs.
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE.
REQ-017 Transitions: IDLE->DONE on accept of non-shift or shamt=0; IDLE->SHIFT on accept of shift with shamt>0; SHIFT->DONE when remaining shamt reaches 0; DONE->IDLE when out_ready=1.
REQ-018 Ops: 000 add (sub when alt=1 and is_imm=0); 010 signed less-than; 011 unsigned less-than; 100 xor; 110 or; 111 and; 001 sll; 101 srl (alt=0) / sra (alt=1).
REQ-019 Compare results SHALL be zero-extended 0/1; add/sub wrap modulo 2^XLEN.
REQ-020 shamt SHALL be op_b[log2(XLEN)-1:0]; upper op_b bits ignored for shifts.
REQ-021 Each SHIFT cycle SHALL shift by min(SHIFT_STEP, remaining); sra fills with captured op_a sign bit.
REQ-022 Latency accept-to-out_valid SHALL be 1 cycle non-shift, 1+ceil(shamt/SHIFT_STEP) cycles shift.
REQ-023 out_valid=1 exactly in DONE; result SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 No new request accepted in the cycle DONE is left (no bypass); next accept at earliest the following cycle.
REQ-025 Undefined funct3/alt combinations (e.g. alt=1 with funct3 001) SHALL execute the alt=0 operation.

Reset
REQ-026 Asserting rst SHALL immediately force state IDLE, out_valid=0, result=0, clear shift counter, regardless of operation in progress.
REQ-027 in_ready SHALL be 0 while rst is asserted and 1 from the first cycle after deassertion.
REQ-028 An operation interrupted by reset SHALL be discarded with no result produced.

Structure
REQ-029 Package alu_pkg SHALL hold funct3 operation constants and the FSM state typedef.
REQ-030 Sub-module alu_shift_step (combinational: value, amount<=SHIFT_STEP, direction, arithmetic -> shifted value) SHALL perform one SHIFT cycle.

Verification
REQ-031 XLEN=32: add op_a=0xFFFFFFFF, op_b=1 -> result 0x00000000, out_valid one cycle after accept.
REQ-032 sltu op_a=1, op_b=0xFFFFFFFF -> 1; slt same operands -> 0.
REQ-033 SHIFT_STEP=1: sra op_a=0x80000000, shamt=31 -> 0xFFFFFFFF after 32 cycles; SHIFT_STEP=8: same -> 5 cycles.
REQ-034 sll shamt=0, op_a=0x12345678 -> 0x12345678 after 1 cycle; op_b=0x25 -> shift by 5.
REQ-035 Hold out_ready=0 for 4 cycles in DONE -> result/out_valid stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-036 Assert rst mid-SHIFT -> out_valid=0, result=0 immediately; after release, new xor 0xF0F0^0x0FF0 -> 0xFF00.
